// File: rtl/clk_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module  : clk_freq_monitor
// Brief   : Counts rising edges of an asynchronous monitored clock over a
//           programmable gate window in the clk_i domain, range-checks each
//           window and declares lock after LOCK_COUNT consecutive good windows.
//           Build option: define CLK_FREQ_MON_STICKY_LOSS_EN for a sticky lost_o.
// Revision: 1.0 - initial release
// ============================================================================
module clk_freq_monitor #(
    parameter int WIN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 enable_i,
    input  logic                 meas_i,
    input  logic [WIN_WIDTH-1:0] win_len_i,
    input  logic [CNT_WIDTH-1:0] exp_cnt_i,
    input  logic [CNT_WIDTH-1:0] tol_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 count_valid_o,
    output logic                 in_range_o,
    output logic                 locked_o,
    output logic                 lost_o
);

    // good_cnt only needs to hold 0..LOCK_COUNT-1; reaching LOCK_COUNT is a transition
    localparam int                   GOOD_W      = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [GOOD_W-1:0]    c_GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [WIN_WIDTH-1:0] c_WIN_ONE   = WIN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync3;
    logic [WIN_WIDTH-1:0] r_win_cnt;
    logic [CNT_WIDTH-1:0] r_edge_cnt;
    logic [GOOD_W-1:0]    r_good_cnt;
    logic [GOOD_W-1:0]    w_good_nxt;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_count_valid;
    logic                 r_in_range;
    logic                 r_lost;

    logic                 w_edge;
    logic                 w_win_end;
    logic                 w_in_range;
    logic                 w_lose;
    logic [WIN_WIDTH-1:0] w_win_load;
    logic [CNT_WIDTH-1:0] w_final_cnt;
    logic [CNT_WIDTH:0]   w_cnt_ext;
    logic [CNT_WIDTH:0]   w_exp_ext;
    logic [CNT_WIDTH:0]   w_diff;

    assign w_edge      = r_sync2 & ~r_sync3;
    assign w_win_load  = (win_len_i == '0) ? c_WIN_ONE : win_len_i;
    assign w_win_end   = (r_state != ST_IDLE) && (r_win_cnt == c_WIN_ONE);
    // An edge in the closing cycle still belongs to the closing window
    assign w_final_cnt = (w_edge && (r_edge_cnt != '1)) ? r_edge_cnt + CNT_WIDTH'(1) : r_edge_cnt;

    assign w_cnt_ext   = {1'b0, w_final_cnt};
    assign w_exp_ext   = {1'b0, exp_cnt_i};
    assign w_diff      = (w_cnt_ext >= w_exp_ext) ? (w_cnt_ext - w_exp_ext) : (w_exp_ext - w_cnt_ext);
    assign w_in_range  = (w_diff <= {1'b0, tol_i});

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_lose      = 1'b0;
        if (!enable_i) begin
            w_state_nxt = ST_IDLE;
            w_good_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = '0;
                end
                ST_ACQUIRE: begin
                    if (w_win_end) begin
                        if (!w_in_range) begin
                            w_good_nxt = '0;
                        end else if (r_good_cnt == c_GOOD_LAST) begin
                            w_state_nxt = ST_LOCKED;
                            w_good_nxt  = '0;
                        end else begin
                            w_good_nxt = r_good_cnt + GOOD_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_win_end && !w_in_range) begin
                        w_state_nxt = ST_ACQUIRE;
                        w_good_nxt  = '0;
                        w_lose      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync3       <= 1'b0;
            r_state       <= ST_IDLE;
            r_good_cnt    <= '0;
            r_win_cnt     <= '0;
            r_edge_cnt    <= '0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_in_range    <= 1'b0;
            r_lost        <= 1'b0;
        end else begin
            r_sync1       <= meas_i;
            r_sync2       <= r_sync1;
            r_sync3       <= r_sync2;
            r_state       <= w_state_nxt;
            r_good_cnt    <= w_good_nxt;
            r_count_valid <= 1'b0;
            if (!enable_i) begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
                r_in_range <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                // Leaving IDLE: the first window begins with the next cycle
                r_win_cnt  <= w_win_load;
                r_edge_cnt <= '0;
            end else if (w_win_end) begin
                r_win_cnt     <= w_win_load;
                r_edge_cnt    <= '0;
                r_count       <= w_final_cnt;
                r_count_valid <= 1'b1;
                r_in_range    <= w_in_range;
            end else begin
                r_win_cnt  <= r_win_cnt - c_WIN_ONE;
                r_edge_cnt <= w_final_cnt;
            end
`ifdef CLK_FREQ_MON_STICKY_LOSS_EN
            if (!enable_i) begin
                r_lost <= 1'b0;
            end else if (w_lose) begin
                r_lost <= 1'b1;
            end
`else
            r_lost <= w_lose;
`endif
        end
    end

    assign count_o       = r_count;
    assign count_valid_o = r_count_valid;
    assign in_range_o    = r_in_range;
    assign locked_o      = (r_state == ST_LOCKED);
    assign lost_o        = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_freq_monitor
// Brief   : Scoreboard bench: a 16-bit instance (LOCK_COUNT=4) and a 3-bit
//           saturating instance (LOCK_COUNT=1) share randomized stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clk_freq_monitor;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        srst_i;
    logic        enable_i;
    logic        meas_i;
    logic [15:0] win_len_i;
    logic [15:0] exp_cnt_i;
    logic [15:0] tol_i;
    logic [15:0] count_a;
    logic        valid_a, inr_a, lck_a, lst_a;
    logic [2:0]  count_b;
    logic        valid_b, inr_b, lck_b, lst_b;

    clk_freq_monitor #(.WIN_WIDTH(16), .CNT_WIDTH(16), .LOCK_COUNT(4)) u_dut_a (
        .clk_i(clk_i), .srst_i(srst_i), .enable_i(enable_i), .meas_i(meas_i),
        .win_len_i(win_len_i), .exp_cnt_i(exp_cnt_i), .tol_i(tol_i),
        .count_o(count_a), .count_valid_o(valid_a), .in_range_o(inr_a),
        .locked_o(lck_a), .lost_o(lst_a)
    );

    clk_freq_monitor #(.WIN_WIDTH(16), .CNT_WIDTH(3), .LOCK_COUNT(1)) u_dut_b (
        .clk_i(clk_i), .srst_i(srst_i), .enable_i(enable_i), .meas_i(meas_i),
        .win_len_i(win_len_i), .exp_cnt_i(exp_cnt_i[2:0]), .tol_i(tol_i[2:0]),
        .count_o(count_b), .count_valid_o(valid_b), .in_range_o(inr_b),
        .locked_o(lck_b), .lost_o(lst_b)
    );

    typedef struct { int cnt; bit inr; bit lck; bit lst; } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    bit   mhist[$];          // meas_i value sampled at each posedge, by index
    int   seg_half[$];       // per-window meas half-period (0 = held low)
    int   checks   = 0;
    int   failures = 0;

    int   good   [2];
    bit   locked [2];
    bit   sticky [2];
    int   mon_cnt[2];
    bit   mon_inr[2];
    bit   mon_lck[2];
    bit   mon_lst[2];
    bit   mon_on = 1'b0;

    int   meas_half = 0;
    int   meas_ph   = 0;
    bit   meas_lvl  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step_meas();
        if (meas_half == 0) begin
            meas_lvl = 1'b0;
        end else begin
            meas_ph++;
            if (meas_ph >= meas_half) begin
                meas_ph  = 0;
                meas_lvl = ~meas_lvl;
            end
        end
    endtask

    // Reference: edges = rising transitions of meas seen 2..3 samples back
    task automatic close_window(input int first_p, input int last_p);
        int edges;
        edges = 0;
        for (int p = first_p; p <= last_p; p++)
            if (p >= 3 && mhist[p-2] && !mhist[p-3]) edges++;
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            int maxv, ex, tl, lc, d;
            maxv  = (i == 0) ? 65535 : 7;
            ex    = (i == 0) ? int'(exp_cnt_i) : int'(exp_cnt_i[2:0]);
            tl    = (i == 0) ? int'(tol_i) : int'(tol_i[2:0]);
            lc    = (i == 0) ? 4 : 1;
            e.cnt = (edges > maxv) ? maxv : edges;
            d     = (e.cnt > ex) ? e.cnt - ex : ex - e.cnt;
            e.inr = (d <= tl);
            e.lst = 1'b0;
            if (!locked[i]) begin
                if (e.inr) begin
                    good[i]++;
                    if (good[i] >= lc) begin
                        locked[i] = 1'b1;
                        good[i]   = 0;
                    end
                end else begin
                    good[i] = 0;
                end
            end else if (!e.inr) begin
                locked[i] = 1'b0;
                good[i]   = 0;
                sticky[i] = 1'b1;
                e.lst     = 1'b1;
            end
            e.lck = locked[i];
`ifdef CLK_FREQ_MON_STICKY_LOSS_EN
            e.lst = sticky[i];
`endif
            if (i == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
    endtask

    task automatic clear_model(input bit rst);
        for (int i = 0; i < 2; i++) begin
            good[i]    = 0;
            locked[i]  = 1'b0;
            sticky[i]  = 1'b0;
            mon_inr[i] = 1'b0;
            mon_lck[i] = 1'b0;
            mon_lst[i] = 1'b0;
            if (rst) mon_cnt[i] = 0;
        end
    endtask

    // Drive one cycle of inputs; if it is a window-closing posedge, predict first
    task automatic tick(input bit en, input bit rst, input bit close, input int first_p);
        srst_i   = rst;
        enable_i = en;
        step_meas();
        meas_i   = rst ? 1'b0 : meas_lvl;
        mhist.push_back(meas_i);
        if (close) close_window(first_p, mhist.size() - 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic mon_side(input int i, input logic v, input int c,
                            input logic inr, input logic lck, input logic lst);
        exp_t e;
        int   depth;
        depth = (i == 0) ? q_a.size() : q_b.size();
        if (v) begin
            checks++;
            if (depth == 0) begin
                failures++;
                $display("FAIL dut%0d_valid actual=pulse required=no_window_due", i);
            end else begin
                if (i == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                check($sformatf("dut%0d_count", i), c, e.cnt);
                check($sformatf("dut%0d_in_range", i), int'(inr), int'(e.inr));
                check($sformatf("dut%0d_locked", i), int'(lck), int'(e.lck));
                check($sformatf("dut%0d_lost", i), int'(lst), int'(e.lst));
                mon_cnt[i] = e.cnt;
                mon_inr[i] = e.inr;
                mon_lck[i] = e.lck;
`ifdef CLK_FREQ_MON_STICKY_LOSS_EN
                mon_lst[i] = e.lst;
`endif
            end
        end else begin
            check($sformatf("dut%0d_hold_count", i), c, mon_cnt[i]);
            check($sformatf("dut%0d_hold_in_range", i), int'(inr), int'(mon_inr[i]));
            check($sformatf("dut%0d_hold_locked", i), int'(lck), int'(mon_lck[i]));
            check($sformatf("dut%0d_hold_lost", i), int'(lst), int'(mon_lst[i]));
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_on) begin
            mon_side(0, valid_a, int'(count_a), inr_a, lck_a, lst_a);
            mon_side(1, valid_b, int'(count_b), inr_b, lck_b, lst_b);
        end
    end

    // term: 0 = disable, 1 = reset, at offset off (1..window length) of the next window
    task automatic run_segment(input int n, input int ex, input int tl, input int nwin,
                               input int term, input int off);
        int nn, e_p;
        nn        = (n == 0) ? 1 : n;
        win_len_i = 16'(n);
        tick(1'b1, 1'b0, 1'b0, 0);
        e_p = mhist.size() - 1;
        for (int j = 1; j <= nwin; j++) begin
            meas_half = seg_half[j-1];
            for (int s = 1; s <= nn; s++) begin
                if (s == nn) begin
                    win_len_i = 16'(n);
                    exp_cnt_i = 16'(ex);
                    tol_i     = 16'(tl);
                end else begin
                    win_len_i = 16'($urandom);
                    exp_cnt_i = 16'($urandom);
                    tol_i     = 16'($urandom);
                end
                tick(1'b1, 1'b0, s == nn, e_p + (j - 1) * nn + 1);
            end
        end
        for (int s = 1; s < off; s++) begin
            win_len_i = 16'($urandom);
            tick(1'b1, 1'b0, 1'b0, 0);
        end
        if (term == 0) begin
            tick(1'b0, 1'b0, 1'b0, 0);
            clear_model(1'b0);
            check("disable_locked", int'(lck_a), 0);
            check("disable_lost", int'(lst_a), 0);
        end else begin
            tick(1'b1, 1'b1, 1'b0, 0);
            clear_model(1'b1);
            check("reset_count", int'(count_a), 0);
            check("reset_valid", int'(valid_a), 0);
            check("reset_locked", int'(lck_a), 0);
            tick(1'b0, 1'b1, 1'b0, 0);
        end
        check("dut0_pending_windows", q_a.size(), 0);
        check("dut1_pending_windows", q_b.size(), 0);
        for (int s = 0; s < 3; s++) tick(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, nn, base, nwin, ex;
        srst_i    = 1'b1;
        enable_i  = 1'b0;
        meas_i    = 1'b0;
        win_len_i = '0;
        exp_cnt_i = '0;
        tol_i     = '0;
        tick(1'b0, 1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, 1'b0, 0);
        clear_model(1'b1);
        check("por_count", int'(count_a), 0);
        check("por_valid", int'(valid_a), 0);
        check("por_in_range", int'(inr_a), 0);
        check("por_locked", int'(lck_a), 0);
        check("por_lost", int'(lst_a), 0);
        mon_on = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 0);

        // Lock at clk/4, lose at clk/8, relock, then disable while locked
        seg_half = '{2, 2, 2, 2, 2, 2, 4, 2, 2, 2, 2, 2};
        run_segment(100, 25, 1, 12, 0, 50);
        // Three good windows, a dead one, then good again; reset mid-window
        seg_half = '{2, 2, 2, 0, 2, 2, 2, 2, 2};
        run_segment(100, 25, 1, 9, 1, 50);
        // Zero window length with static input and zero expectation
        seg_half = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_segment(0, 0, 0, 10, 0, 1);
        // Maximum expectation against zero count
        seg_half = '{0, 0, 0};
        run_segment(20, 65535, 0, 3, 0, 5);

        for (int k = 0; k < 30; k++) begin
            n    = $urandom_range(0, 40);
            nn   = (n == 0) ? 1 : n;
            nwin = $urandom_range(1, 8);
            base = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(2, 6);
            seg_half.delete();
            for (int j = 0; j < nwin; j++)
                seg_half.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : base);
            ex = (base == 0) ? 0 : nn / (2 * base);
            ex = ex + $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) ex = 65535;
            run_segment(n, ex, $urandom_range(0, 2), nwin, $urandom_range(0, 1),
                        $urandom_range(1, nn));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
